// File: rtl/demux_pkg.sv
// Shared constants and helpers for the demux_param receive-path demultiplexer.
package demux_pkg;

    localparam logic MODO_RR  = 1'b0;
    localparam logic MODO_DIR = 1'b1;

    // Widest lane count the onehot() helper can encode.
    localparam int unsigned MAX_CH = 32;

    // One-hot lane mask for sel; all zeros when sel is not a legal lane.
    function automatic logic [MAX_CH-1:0] onehot(input int unsigned sel,
                                                 input int unsigned num_ch);
        logic [MAX_CH-1:0] mask;
        mask = '0;
        if (sel < num_ch && sel < MAX_CH) begin
            mask = {{(MAX_CH-1){1'b0}}, 1'b1} << sel;
        end
        return mask;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// Single output-lane holding register: loads on enable, synchronous active-high clear.
module demux_lane_reg #(
    parameter int unsigned BUS_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [BUS_W-1:0] d_i,
    output logic [BUS_W-1:0] q_o
);

    logic [BUS_W-1:0] lane_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lane_q <= '0;
        end else if (load_i) begin
            lane_q <= d_i;
        end
    end

    assign q_o = lane_q;

endmodule

// File: rtl/demux_param.sv
// 1-to-NUM_CH demultiplexer: round-robin group assembly or sel-steered routing, registered outputs.
// Define DEMUX_PARTIAL_FLUSH_EN to flush partial round-robin groups on mode switch or 2 idle cycles.
module demux_param
    import demux_pkg::*;
#(
    parameter int unsigned BUS_W  = 8,
    parameter int unsigned NUM_CH = 4,  // 2 .. MAX_CH
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk_4f,
    input  logic                    reset,
    input  logic                    valid_entrada,
    input  logic [BUS_W-1:0]        entrada,
    input  logic                    modo,
    input  logic [SEL_W-1:0]        sel,
    output logic [NUM_CH*BUS_W-1:0] salida,
    output logic [NUM_CH-1:0]       valid_salida,
    output logic                    err_sel
);

    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  ptr_eff;
    logic              modo_q;
    logic [BUS_W-1:0]  grp_q  [NUM_CH];
    logic [BUS_W-1:0]  grp_d  [NUM_CH];
    logic [BUS_W-1:0]  lane_d [NUM_CH];
    logic [NUM_CH-1:0] lane_load;
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic              err_q, err_d;
    logic              mode_switch;
    logic              flush;
    logic [NUM_CH-1:0] sel_oh;

    assign mode_switch = (modo != modo_q);
    // A word arriving on a switch cycle starts from lane 0 under the new mode.
    assign ptr_eff     = mode_switch ? '0 : ptr_q;
    assign sel_oh      = NUM_CH'(onehot(32'(sel), NUM_CH));

`ifdef DEMUX_PARTIAL_FLUSH_EN
    logic idle_q;

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            idle_q <= 1'b0;
        end else begin
            idle_q <= ~valid_entrada;
        end
    end

    assign flush = (modo_q == MODO_RR) && (ptr_q != '0) &&
                   (mode_switch || (idle_q && !valid_entrada));
`else
    assign flush = 1'b0;
`endif

    always_comb begin
        ptr_d     = ptr_q;
        grp_d     = grp_q;
        lane_load = '0;
        valid_d   = '0;
        err_d     = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            lane_d[k] = grp_q[k];
        end

        if (flush) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (k < 32'(ptr_q)) begin
                    lane_load[k] = 1'b1;
                    valid_d[k]   = 1'b1;
                end
            end
        end

        if (mode_switch || flush) begin
            ptr_d = '0;
        end

        if (valid_entrada) begin
            if (modo == MODO_RR) begin
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (k == 32'(ptr_eff)) begin
                        grp_d[k] = entrada;
                    end
                end
                if (ptr_eff == PTR_LAST) begin
                    lane_load = '1;
                    valid_d   = '1;
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        lane_d[k] = grp_d[k];
                    end
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_eff + SEL_W'(1);
                end
            end else if (sel_oh != '0) begin
                // Steered word wins its lane even if a switch flush lands on the same cycle.
                for (int unsigned k = 0; k < NUM_CH; k++) begin
                    if (sel_oh[k]) begin
                        lane_load[k] = 1'b1;
                        lane_d[k]    = entrada;
                    end
                end
                valid_d = valid_d | sel_oh;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            ptr_q   <= '0;
            modo_q  <= MODO_RR;
            grp_q   <= '{default: '0};
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            modo_q  <= modo;
            grp_q   <= grp_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        demux_lane_reg #(
            .BUS_W(BUS_W)
        ) u_lane (
            .clk_i (clk_4f),
            .rst_i (reset),
            .load_i(lane_load[k]),
            .d_i   (lane_d[k]),
            .q_o   (salida[k*BUS_W +: BUS_W])
        );
    end

    assign valid_salida = valid_q;
    assign err_sel      = err_q;

endmodule

// File: doc/demux_param.md
# demux_param

Parametrised single-clock 1-to-NUM_CH demultiplexer, successor to the fixed 8-bit 1-to-4 multi-clock demux in the receive path. It accepts one word per cycle on a valid-qualified input. In round-robin mode it assembles NUM_CH consecutive words into one parallel group; in steered mode it routes each word to the lane given by a select input. All outputs are registered, with per-lane valids and an error pulse for illegal selects.

## Interface
- BUS_W, default 8: word width in bits, ≥1.
- NUM_CH, default 4: number of output lanes, ≥2. Need not be a power of two.
- SEL_W, default $clog2(NUM_CH): select width, derived, not overridden.
- clk_4f  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-high; sampled on clk_4f rising edge.
- valid_entrada  input  1  entrada holds a valid word this cycle.
- entrada  input  BUS_W  input word.
- modo  input  1  0 = round-robin group (MODO_RR), 1 = steered (MODO_DIR).
- sel  input  SEL_W  target lane in MODO_DIR; ignored in MODO_RR.
- salida  output  NUM_CH*BUS_W  lane k occupies bits [k*BUS_W +: BUS_W].
- valid_salida  output  NUM_CH  per-lane valid, single-cycle pulses.
- err_sel  output  1  one-cycle pulse: word dropped because sel ≥ NUM_CH.

## Operation
- Reset, every output: salida = 0, valid_salida = 0, err_sel = 0. Internal state: ptr = 0, group buffer = 0, modo_q = 0.
- MODO_RR:
  - Each valid word goes to buffer[ptr], then ptr increments.
  - When the word lands at ptr = NUM_CH−1, the group is complete. Next cycle: salida = full buffer including that word, valid_salida = all ones. ptr wraps to 0.
  - Non-valid cycles leave ptr and buffer unchanged; the group waits.
- MODO_DIR, valid word with sel < NUM_CH: next cycle, lane sel of salida = word and valid_salida = one-hot(sel). Other lanes hold their previous data with valid 0.
- MODO_DIR, sel ≥ NUM_CH: word dropped, err_sel = 1 next cycle, salida unchanged.
- modo is registered as modo_q. When modo ≠ modo_q on a cycle, that cycle is a mode switch:
  - Any RR partial group is handled per Configuration, and ptr is forced to 0.
  - A word valid on the switch cycle is processed under the new mode.
- Data lanes never return to 0 except on reset. valid_salida is the only qualifier.

## Timing
- Latency: 1 cycle from the accepting edge to the registered output, in both modes.
- Throughput: 1 word/cycle sustained. In RR, a full group appears every NUM_CH valid cycles. Back-to-back groups have no bubble.
- Wrap: with ptr = NUM_CH−1, a valid word completes the group and sets ptr = 0 on the same edge. A valid word on the next cycle starts the new group at lane 0.
- Reset mid-group: the partial group is discarded and no output pulse is produced. Reset has priority over every other event.
- Mode switch and group completion on the same cycle: the word is processed under the new mode, so it does not complete the old group.

## Configuration
- DEMUX_PARTIAL_FLUSH_EN, defined: partial RR groups are flushed.
  - Trigger: a mode switch, or valid_entrada low for 2 consecutive cycles with ptr ≠ 0.
  - Next cycle, salida carries the buffered lanes 0..ptr−1 and valid_salida has only those bits set. ptr then goes to 0.
- DEMUX_PARTIAL_FLUSH_EN, undefined:
  - A mode switch silently discards the partial group.
  - Idle cycles never flush; a partial group waits indefinitely for completion.

## Structure
- Package demux_pkg: localparams MODO_RR = 1'b0, MODO_DIR = 1'b1, and function onehot(sel, NUM_CH).
- Sub-module demux_lane_reg (BUS_W): one lane holding register with load enable and synchronous reset. demux_param instantiates it NUM_CH times via generate.
- The control path (ptr, modo_q, idle counter, valid/err generation) stays in demux_param.

## Test plan
- Reset: hold reset 3 cycles with valid_entrada = 1 → all outputs 0. After release, ptr = 0 (first RR word lands on lane 0).
- RR full groups, NUM_CH = 4, BUS_W = 8: words 0x11, 0x22, 0x33, 0x44, 0x55… on consecutive cycles.
  - One cycle after 0x44, salida = {0x44, 0x33, 0x22, 0x11} with valid_salida = 4'b1111.
  - Next group starts with 0x55 on lane 0, with no gap.
- RR with gaps: valid pattern 1, 0, 1, 1, 0, 1 → valid_salida = 4'b1111 exactly once, one cycle after the 4th valid word.
- MODO_DIR: sel = 2 with 0xA5 → next cycle valid_salida = 4'b0100 and lane 2 = 0xA5. Then NUM_CH = 3, sel = 3 → err_sel pulses once and salida is unchanged.
- Mode switch with 2 words buffered:
  - Flush macro defined: valid_salida = 4'b0011.
  - Flush macro undefined: no output pulse, and the next RR word lands on lane 0.
- Partial flush on idle (macro defined): 3 words, then 2 idle cycles → valid_salida = 4'b0111 on the cycle after the 2nd idle cycle.
